regfile_wr_arbiter: RTL

//  Round-robin arbiter that shares one register-bank write port among NREQ requesters.

---
 rtl/wrarb_pkg.sv | 33 +++
 rtl/rr_pick.sv | 43 ++++
 rtl/regfile_wr_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/wrarb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wrarb_pkg
// Description : Shared sizes, the requester index type and helpers for the
//               register-bank write arbiter.
// Revision    : 1.0  initial release
// ============================================================================
package wrarb_pkg;

    localparam int NREQ = 4;     // number of requesters
    localparam int AW   = 3;     // register address width
    localparam int NREG = 8;     // registers in bank (2**AW)
    localparam int DW   = 32;    // data width
    localparam int IW   = $clog2(NREQ);

    typedef logic [IW-1:0] req_idx_t;

    // Register address to one-hot bank enable
    function automatic logic [NREG-1:0] onehot_dec(input logic [AW-1:0] a);
        onehot_dec    = '0;
        onehot_dec[a] = 1'b1;
    endfunction

    // (a + b) mod NREQ, valid for NREQ that is not a power of two as well
    function automatic req_idx_t idx_add(input req_idx_t a, input req_idx_t b);
        int s;
        s = int'(a) + int'(b);
        if (s >= NREQ) s = s - NREQ;
        return req_idx_t'(s);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin finder. Rotates the eligible set so
//               the pointer position becomes bit 0, takes the lowest set bit,
//               then rotates the index back.
// Revision    : 1.0  initial release
// ============================================================================
module rr_pick
    import wrarb_pkg::*;
(
    input  logic [NREQ-1:0] e,
    input  req_idx_t        rr_ptr,
    output logic            valid,
    output req_idx_t        w
);

    logic [NREQ-1:0] w_rot;
    req_idx_t        w_off;

    // Rotate eligible set so that requester rr_ptr lands on bit 0
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_rot[i] = e[idx_add(req_idx_t'(i), rr_ptr)];
        end
    end

    // Lowest set bit of the rotated vector, mapped back to a requester index
    always_comb begin
        valid = 1'b0;
        w_off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                valid = 1'b1;
                w_off = req_idx_t'(i);
            end
        end
        w = idx_add(w_off, rr_ptr);
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_arbiter
// Description : Round-robin arbiter sharing one register-bank write port among
//               NREQ requesters. Registered one-hot grant, one-hot register
//               enable and write data, one cycle after the request.
//               Optional macro WRARB_AGE_EN adds per-requester age counters;
//               a requester that has waited MAXWAIT cycles beats round-robin.
// Revision    : 1.0  initial release
// ============================================================================
module regfile_wr_arbiter
    import wrarb_pkg::*;
#(
    parameter int MAXWAIT = 7
)
(
    input  logic               clk,
    input  logic               r,
    input  logic               stall,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREG-1:0]    wr_en,
    output logic [DW-1:0]      wr_data,
    output logic               busy
);

    localparam req_idx_t c_last = req_idx_t'(NREQ - 1);

    logic [NREQ-1:0] r_gnt;
    logic [NREG-1:0] r_wr_en;
    logic [DW-1:0]   r_wr_data;
    req_idx_t        r_rr_ptr;

    logic [NREQ-1:0] w_elig;
    logic            w_rr_valid;
    req_idx_t        w_rr_w;
    req_idx_t        w_win;
    logic            w_take;
    logic [NREQ-1:0] w_gnt_nxt;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_data;

    // The requester granted right now sits out one cycle
    assign w_elig = req & ~r_gnt;
    assign busy   = |req;

    rr_pick u_rr_pick (
        .e      (w_elig),
        .rr_ptr (r_rr_ptr),
        .valid  (w_rr_valid),
        .w      (w_rr_w)
    );

`ifdef WRARB_AGE_EN
    localparam int              AGEW      = $clog2(MAXWAIT + 1);
    localparam logic [AGEW-1:0] c_age_max = AGEW'(MAXWAIT);

    logic [AGEW-1:0] r_age [NREQ];
    logic            w_force;
    req_idx_t        w_force_w;

    // Starved eligible requester overrides round-robin, lowest index first
    always_comb begin
        w_force   = 1'b0;
        w_force_w = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_elig[i] && (r_age[i] == c_age_max)) begin
                w_force   = 1'b1;
                w_force_w = req_idx_t'(i);
            end
        end
    end

    assign w_win = w_force ? w_force_w : w_rr_w;

    // Age counters: count waiting cycles, clear on grant or withdrawal, hold in stall
    always_ff @(posedge clk) begin
        if (r) begin
            for (int i = 0; i < NREQ; i++) r_age[i] <= '0;
        end else if (!stall) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] || w_gnt_nxt[i]) begin
                    r_age[i] <= '0;
                end else if (r_age[i] != c_age_max) begin
                    r_age[i] <= r_age[i] + 1'b1;
                end
            end
        end
    end
`else
    assign w_win = w_rr_w;
`endif

    assign w_take = !stall && w_rr_valid;

    // Next-cycle grant vector and the winner's address/data
    always_comb begin
        w_gnt_nxt  = '0;
        w_sel_addr = '0;
        w_sel_data = '0;
        if (w_take) w_gnt_nxt[w_win] = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == req_idx_t'(i)) begin
                w_sel_addr = addr[i*AW +: AW];
                w_sel_data = wdata[i*DW +: DW];
            end
        end
    end

    // Output registers and round-robin pointer
    always_ff @(posedge clk) begin
        if (r) begin
            r_gnt     <= '0;
            r_wr_en   <= '0;
            r_wr_data <= '0;
            r_rr_ptr  <= '0;
        end else if (w_take) begin
            r_gnt     <= w_gnt_nxt;
            r_wr_en   <= onehot_dec(w_sel_addr);
            r_wr_data <= w_sel_data;
            r_rr_ptr  <= (w_win == c_last) ? '0 : w_win + 1'b1;
        end else begin
            r_gnt     <= '0;
            r_wr_en   <= '0;
        end
    end

    assign gnt     = r_gnt;
    assign wr_en   = r_wr_en;
    assign wr_data = r_wr_data;

endmodule
`default_nettype wire
